// File: rtl/typePack.sv
// typePack: types shared by the fetch stage and the core.
package typePack;

  typedef logic [31:0] instruction_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam instruction_t NOP_INST = 32'h0000_0013;

  typedef struct packed {
    instruction_t inst;
    logic [31:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush.
// Head entry reads as zero while the FIFO is empty.
module fetch_fifo
  import typePack::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  fetch_entry_t          data_i,
  output fetch_entry_t          head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i &&
                   ((cnt_q != (AW+1)'(DEPTH)) || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      if (do_push && !do_pop)
        cnt_d = cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push)
        cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: sequential fetch, in-order response buffer, redirect flush.
// FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect halt and fault flag.
module inst_fetch
  import typePack::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic         CLOCK,
  input  logic         RESET_N,
  output logic         MEM_REQ_VALID,
  input  logic         MEM_REQ_READY,
  output logic [31:0]  MEM_REQ_ADDR,
  input  logic         MEM_RSP_VALID,
  input  logic [31:0]  MEM_RSP_DATA,
  output instruction_t INST,
  output logic [31:0]  INST_PC,
  output logic         INST_VALID,
  input  logic         INST_READY,
  input  logic         REDIRECT_VALID,
  input  logic [31:0]  REDIRECT_PC,
  output logic         FETCH_FAULT
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] fifo_cnt;
  logic [CW+1:0] credit_used;
  logic [31:0]   redir_pc;
  logic          misalign;
  logic          req_fire, rsp_keep, rsp_drop;
  logic          push, pop;
  fetch_entry_t  head, push_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  assign redir_pc = REDIRECT_PC;
  assign misalign = REDIRECT_PC[1:0] != 2'b00;

  always_comb begin
    fault_d = fault_q;
    if (REDIRECT_VALID) fault_d = misalign;
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) fault_q <= 1'b0;
    else          fault_q <= fault_d;
  end

  assign FETCH_FAULT = fault_q;
`else
  logic unused_pc_bits;

  assign unused_pc_bits = ^REDIRECT_PC[1:0];
  assign redir_pc    = {REDIRECT_PC[31:2], 2'b00};
  assign misalign    = 1'b0;
  assign FETCH_FAULT = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (REDIRECT_VALID) state_d = misalign ? HALT : RUN;
  end

  // Discarded responses still hold a credit until they come back.
  assign credit_used = {2'b00, outst_q} +
                       {2'b00, fifo_cnt} +
                       {2'b00, disc_q};

  always_comb begin
    MEM_REQ_VALID = RESET_N && (state_q == RUN) &&
                    (credit_used < DEPTH_W);
  end

  assign req_fire = MEM_REQ_VALID && MEM_REQ_READY;
  assign rsp_drop = MEM_RSP_VALID && (disc_q != '0);
  assign rsp_keep = MEM_RSP_VALID && (disc_q == '0);
  assign push     = rsp_keep && !REDIRECT_VALID;
  assign pop      = INST_VALID && INST_READY && !REDIRECT_VALID;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    disc_d     = disc_q;
    if (REDIRECT_VALID) begin
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      outst_d    = '0;
      disc_d     = outst_q + disc_q + CW'(req_fire) -
                   CW'(MEM_RSP_VALID);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)     rsp_pc_d   = rsp_pc_q + 32'd4;
      if (rsp_drop) disc_d     = disc_q - CW'(1);
      outst_d = outst_q + CW'(req_fire) - CW'(rsp_keep);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
    end
  end

  assign push_entry = '{inst: MEM_RSP_DATA, pc: rsp_pc_q};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLOCK),
    .rst_ni  (RESET_N),
    .flush_i (REDIRECT_VALID),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (fifo_cnt)
  );

  assign MEM_REQ_ADDR = fetch_pc_q;
  assign INST         = head.inst;
  assign INST_PC      = head.pc;
  assign INST_VALID   = fifo_cnt != '0;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: vector table plus directed redirect/reset sequences.
// Memory model answers in order after a fixed latency.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, inst_ready;
  logic        redir;
  logic [31:0] redir_pc;
  logic        fault;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cyc    = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .CLOCK          (clk),
    .RESET_N        (rst_n),
    .MEM_REQ_VALID  (req_valid),
    .MEM_REQ_READY  (req_ready),
    .MEM_REQ_ADDR   (req_addr),
    .MEM_RSP_VALID  (rsp_valid),
    .MEM_RSP_DATA   (rsp_data),
    .INST           (inst),
    .INST_PC        (inst_pc),
    .INST_VALID     (inst_valid),
    .INST_READY     (inst_ready),
    .REDIRECT_VALID (redir),
    .REDIRECT_PC    (redir_pc),
    .FETCH_FAULT    (fault)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hA5C3_0F00;
  endfunction

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  mreq_t mq[$];

  initial begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) mq.delete();
      else if (req_valid && req_ready)
        mq.push_back('{due: cyc + lat, addr: req_addr});
      @(posedge clk);
      cyc++;
      #1;
      if (mq.size() > 0 && mq[0].due == cyc) begin
        rsp_valid = 1'b1;
        rsp_data  = memw(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        rsp_valid = 1'b0;
      end
    end
  end

  typedef struct {
    bit          rst;
    bit          ir;
    bit          rr;
    bit          ev;
    logic [31:0] ea;
    bit          eiv;
    logic [31:0] epc;
    bit          cp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit ir, bit rr, bit ev,
                              logic [31:0] ea, bit eiv,
                              logic [31:0] epc, bit cp);
    vec_t v;
    v.rst = rst; v.ir = ir; v.rr = rr; v.ev = ev;
    v.ea = ea; v.eiv = eiv; v.epc = epc; v.cp = cp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    lat        = l;
    rst_n      = 1'b0;
    inst_ready = 1'b1;
    req_ready  = 1'b1;
    redir      = 1'b0;
    redir_pc   = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_state(input string nm);
    @(negedge clk);
    chk({nm, ".req_valid"}, 32'(req_valid), 32'd1);
    chk({nm, ".addr"}, req_addr, 32'h0);
    chk({nm, ".inst_valid"}, 32'(inst_valid), 32'd0);
    chk({nm, ".inst_pc"}, inst_pc, 32'h0);
    chk({nm, ".inst"}, inst, 32'h0);
    chk({nm, ".fault"}, 32'(fault), 32'd0);
  endtask

  task automatic expect_stream(input logic [31:0] pc0, input int n,
                               input int budget);
    logic [31:0] e;
    int got;
    e   = pc0;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        chk("stream.pc", inst_pc, e);
        chk("stream.inst", inst, memw(e));
        e += 32'd4;
        got++;
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL stream.timeout got=%0d want=%0d", got, n);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; inst_ready = 1'b1; req_ready = 1'b0;
    redir = 1'b0; redir_pc = '0; lat = 1;

    // rst ir rr | ev addr | iv pc | cp
    tbl.push_back(mk(1, 1, 0, 0, 32'd0,  0, 32'd0,  1));
    tbl.push_back(mk(0, 1, 1, 1, 32'd0,  0, 32'd0,  1));
    tbl.push_back(mk(0, 1, 1, 1, 32'd4,  0, 32'd0,  0));
    tbl.push_back(mk(0, 1, 1, 1, 32'd8,  1, 32'd0,  1));
    tbl.push_back(mk(0, 1, 1, 1, 32'd12, 1, 32'd4,  1));
    tbl.push_back(mk(0, 1, 0, 1, 32'd16, 1, 32'd8,  1));
    tbl.push_back(mk(0, 1, 0, 1, 32'd16, 1, 32'd12, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 0, 1, 32'd16, 0, 32'd0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 32'd16, 0, 32'd0,  0));
    tbl.push_back(mk(0, 1, 1, 1, 32'd20, 0, 32'd0,  0));
    tbl.push_back(mk(0, 1, 1, 1, 32'd24, 1, 32'd16, 1));
    tbl.push_back(mk(0, 1, 1, 1, 32'd28, 1, 32'd20, 1));
    tbl.push_back(mk(0, 0, 1, 1, 32'd32, 1, 32'd24, 1));
    tbl.push_back(mk(0, 0, 1, 1, 32'd36, 1, 32'd24, 1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 1, 0, 32'd40, 1, 32'd24, 1));
    tbl.push_back(mk(0, 1, 1, 0, 32'd40, 1, 32'd24, 1));
    tbl.push_back(mk(0, 1, 1, 1, 32'd40, 1, 32'd28, 1));
    tbl.push_back(mk(0, 1, 1, 1, 32'd44, 1, 32'd32, 1));
    tbl.push_back(mk(0, 1, 1, 1, 32'd48, 1, 32'd36, 1));
    tbl.push_back(mk(0, 1, 1, 1, 32'd52, 1, 32'd40, 1));
    tbl.push_back(mk(0, 1, 1, 1, 32'd56, 1, 32'd44, 1));

    tick();
    for (int i = 0; i < tbl.size(); i++) begin
      rst_n      = !tbl[i].rst;
      inst_ready = tbl[i].ir;
      req_ready  = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("t%0d.req_valid", i), 32'(req_valid),
          32'(tbl[i].ev));
      chk($sformatf("t%0d.addr", i), req_addr, tbl[i].ea);
      chk($sformatf("t%0d.inst_valid", i), 32'(inst_valid),
          32'(tbl[i].eiv));
      if (tbl[i].cp) begin
        chk($sformatf("t%0d.inst_pc", i), inst_pc,
            tbl[i].eiv ? tbl[i].epc : 32'h0);
        chk($sformatf("t%0d.inst", i), inst,
            tbl[i].eiv ? memw(tbl[i].epc) : 32'h0);
      end
      tick();
    end

    // Reset while streaming, then redirect with three fetches in flight.
    do_reset(3);
    chk_reset_state("rst_mid");
    tick();
    tick();
    redir = 1'b1; redir_pc = 32'h200;
    tick();
    redir = 1'b0;
    @(negedge clk);
    chk("rd3.inst_valid", 32'(inst_valid), 32'd0);
    chk("rd3.addr", req_addr, 32'h200);
    chk("rd3.req_valid", 32'(req_valid), 32'd1);
    expect_stream(32'h200, 4, 40);

    // Redirect in a cycle with both a request and a response.
    do_reset(1);
    tick(); tick(); tick();
    redir = 1'b1; redir_pc = 32'h300;
    tick();
    redir = 1'b0;
    @(negedge clk);
    chk("rdc.inst_valid", 32'(inst_valid), 32'd0);
    chk("rdc.addr", req_addr, 32'h300);
    expect_stream(32'h300, 3, 20);

    // Fetch address wraps past the top of memory.
    do_reset(1);
    redir = 1'b1; redir_pc = 32'hFFFF_FFF8;
    tick();
    redir = 1'b0;
    @(negedge clk);
    chk("wrap.addr", req_addr, 32'hFFFF_FFF8);
    expect_stream(32'hFFFF_FFF8, 4, 20);

    do_reset(1);
    tick();
    redir = 1'b1; redir_pc = 32'h102;
    tick();
    redir = 1'b0;
    @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis.fault", 32'(fault), 32'd1);
    chk("mis.req_valid", 32'(req_valid), 32'd0);
    tick(); tick();
    @(negedge clk);
    chk("mis.halt_valid", 32'(req_valid), 32'd0);
    chk("mis.halt_inst_valid", 32'(inst_valid), 32'd0);
    tick();
    redir = 1'b1; redir_pc = 32'h100;
    tick();
    redir = 1'b0;
    @(negedge clk);
    chk("mis.fault_clr", 32'(fault), 32'd0);
    chk("mis.resume_valid", 32'(req_valid), 32'd1);
    chk("mis.resume_addr", req_addr, 32'h100);
    expect_stream(32'h100, 2, 20);
`else
    chk("mis.fault", 32'(fault), 32'd0);
    chk("mis.req_valid", 32'(req_valid), 32'd1);
    chk("mis.addr", req_addr, 32'h100);
    expect_stream(32'h100, 3, 20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
